psx_controller: RTL and testbench
=================================

Name: psx_controller

Overview:
- Device-side (responder) end of the PSX pad bus; the counterpart of psx_console, which is the initiator.
- Emulates a PSX digital pad (ID 0x41) to a real PSX console.
- Oversamples ATT/CLK/CMD on sample_clk, shifts reply bytes out on DATA, and pulses ACK between bytes.
- Button state comes from elsewhere in the design, e.g. N64-to-PSX bridging, the reverse of the existing PSX-to-N64 path.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on psx_att/psx_clk/psx_cmd (min 2).
- ACK_DELAY, 40, sample_clk cycles from the byte's 8th CLK rising edge to ACK assertion.
- ACK_WIDTH, 80, sample_clk cycles ACK is held asserted.
- Width rule: ACK counter width is $clog2(max(ACK_DELAY, ACK_WIDTH)+1).

Ports:
- sample_clk  input  1  sole clock, much faster than psx_clk (≥16x).
- rst_n  input  1  synchronous, active-low reset.
- psx_att  input  1  console attention, active low.
- psx_clk  input  1  console bit clock, idles high.
- psx_cmd  input  1  console command bit, LSB first.
- button_state  input  16  active-low PSX button word; bit 0 is sent first.
- psx_data  output  1  reply bit value.
- psx_data_oe  output  1  1 = drive psx_data onto the open-drain line; 0 = release.
- psx_ack_oe  output  1  1 = pull ACK line low.

Behaviour:
- Interface is fixed: one clock, sample_clk; reset rst_n is synchronous and active-low.
- Reset values: psx_data=1, psx_data_oe=0, psx_ack_oe=0, FSM=IDLE, bit_cnt=0, byte_idx=0. Synchronizers are reset to 1.
- Input path: all inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized signals.
- Bit timing:
  - Reply bit changes on the sync'd psx_clk falling edge, one cycle after detection.
  - psx_cmd is sampled on the sync'd rising edge and shifted in LSB first.
  - bit_cnt counts rising edges 0..7. The byte completes on the 8th rising edge.
  - Reply data stays valid until the next falling edge.
- FSM states: IDLE, ADDR, ID, HDR, BTN_LO, BTN_HI, IGNORE, and ACK sub-phases WAIT_ACK and ACKING (tracked per byte).
  - IDLE: on psx_att fall, latch button_state into btn_lat, go to ADDR, psx_data_oe=0.
  - ADDR: reply released (0xFF). At byte end, rx==0x01 leads to an ACK, then ID. Any other rx leads to IGNORE with no ACK.
  - ID: drive 0x41. At byte end, rx==0x42 leads to an ACK, then HDR. Otherwise go to IGNORE and release data.
  - HDR: drive 0x5A. ACK, then BTN_LO.
  - BTN_LO: drive btn_lat[7:0]. ACK, then BTN_HI.
  - BTN_HI: drive btn_lat[15:8]. No ACK after this last byte; go to IGNORE.
  - IGNORE: outputs released; wait for psx_att rise.
- ACK timing:
  - Countdown of ACK_DELAY cycles, then psx_ack_oe=1 for exactly ACK_WIDTH cycles, then 0.
  - A psx_clk falling edge during WAIT_ACK or ACKING aborts the ACK immediately (psx_ack_oe=0) and starts the next byte.
- psx_att rise in any state:
  - Go to IDLE next cycle; psx_data_oe=0, psx_ack_oe=0.
  - Partial byte is discarded; bit_cnt and byte_idx are cleared.
- Extra clocks after BTN_HI are ignored (remain in IGNORE).
- psx_att fall and psx_clk edge detected in the same cycle: the att event takes priority. The clk edge is dropped; the console spec guarantees setup, so this is not a legal case.
- rst_n low mid-transaction: all outputs go to reset values the next cycle; a new transaction begins only after a fresh psx_att fall.
- btn_lat is stable for the whole transaction. button_state changes mid-poll are not visible until the next poll.

Optional Feature:
- Macro: PSX_POLL_SYNC_EN.
- When defined:
  - Adds output poll_req (1 bit), a one-cycle pulse when the ADDR byte completes with rx==0x01.
  - btn_lat is latched at HDR byte completion instead of psx_att fall, so upstream logic can refresh button_state during bytes 1-2.
- When undefined: no poll_req port exists, and the latch occurs at psx_att fall.

Test Plan:
- Full poll: button_state=16'hFFFE, console sends 01 42 00 00 00. DATA reads FF 41 5A FE FF. Four ACK pulses, each ACK_WIDTH cycles, starting ACK_DELAY after byte end. No ACK after byte 5.
- Memory-card address: first byte 0x81. No ACK; psx_data_oe stays 0 for the rest of the transaction; FSM is in IGNORE until att rises.
- Bad command: 01 then 0x43. ACK after byte 1 only; data released after byte 2; no further ACKs.
- Abort: psx_att rises after 3 bits of BTN_LO. Outputs are released within 1+SYNC_STAGES cycles. The next poll with button_state=16'h0F0F returns 0F 0F correctly.
- Reset mid-ACK: rst_n low while psx_ack_oe=1. psx_ack_oe=0 on the next edge, all outputs at reset values.
- PSX_POLL_SYNC_EN: change button_state 16'hFFFF→16'hAAAA during the ID byte. Readback is AA AA; poll_req pulses exactly once per addressed poll.

Source files
------------

// File: rtl/psx_controller.sv
// psx_controller: device-side (responder) end of the PSX pad bus, emulating a
// digital pad (ID 0x41). ATT/CLK/CMD are oversampled on sample_clk; reply bytes
// shift out on DATA and ACK is pulsed between bytes.
//
// Ports:
//   sample_clk    in   sole clock, >= 16x psx_clk
//   rst_n         in   synchronous active-low reset
//   psx_att       in   console attention, active low
//   psx_clk       in   console bit clock, idles high
//   psx_cmd       in   console command bit, LSB first
//   button_state  in   [15:0] active-low button word, bit 0 sent first
//   psx_data      out  reply bit value
//   psx_data_oe   out  1 = drive psx_data onto the open-drain line
//   psx_ack_oe    out  1 = pull ACK low
//   poll_req      out  (PSX_POLL_SYNC_EN only) pulse when ADDR byte == 0x01
//
// Optional feature macro: PSX_POLL_SYNC_EN
//   Adds poll_req and moves the button latch from ATT fall to HDR byte end.
module psx_controller #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACK_DELAY   = 40,
    parameter int unsigned ACK_WIDTH   = 80
) (
    input  logic        sample_clk,
    input  logic        rst_n,
    input  logic        psx_att,
    input  logic        psx_clk,
    input  logic        psx_cmd,
    input  logic [15:0] button_state,
    output logic        psx_data,
    output logic        psx_data_oe,
    output logic        psx_ack_oe
`ifdef PSX_POLL_SYNC_EN
    ,
    output logic        poll_req
`endif
);

    localparam int unsigned ACK_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int unsigned ACK_CW  = $clog2(ACK_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ID, HDR, BTN_LO, BTN_HI, IGNORE
    } state_t;

    typedef enum logic [1:0] {
        ACK_NONE, WAIT_ACK, ACKING
    } ack_t;

    logic [SYNC_STAGES-1:0] r_att_sync, r_clk_sync, r_cmd_sync;
    logic                   r_att_d, r_clk_d;
    state_t                 r_state, w_state_nxt;
    ack_t                   r_ack, w_ack_nxt;
    logic [ACK_CW-1:0]      r_ack_cnt, w_ack_cnt_nxt;
    logic [2:0]             r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]             r_byte_idx, w_byte_idx_nxt;
    logic [7:0]             r_rx, w_rx_nxt;
    logic [15:0]            r_btn_lat, w_btn_lat_nxt;
    logic                   r_data, w_data_nxt;
    logic                   r_data_oe, w_data_oe_nxt;
    logic                   r_ack_oe, w_ack_oe_nxt;
    logic                   w_start_ack;
`ifdef PSX_POLL_SYNC_EN
    logic                   r_poll_req, w_poll_nxt;
`endif

    logic       w_att_s, w_clk_s, w_cmd_s;
    logic       w_att_fall, w_att_rise, w_clk_fall, w_clk_rise;
    logic [7:0] w_rx_byte, w_reply;

    assign w_att_s    = r_att_sync[SYNC_STAGES-1];
    assign w_clk_s    = r_clk_sync[SYNC_STAGES-1];
    assign w_cmd_s    = r_cmd_sync[SYNC_STAGES-1];
    assign w_att_fall = r_att_d & ~w_att_s;
    assign w_att_rise = ~r_att_d & w_att_s;
    assign w_clk_fall = r_clk_d & ~w_clk_s;
    assign w_clk_rise = ~r_clk_d & w_clk_s;
    // LSB arrives first, so shift right and insert at the top
    assign w_rx_byte  = {w_cmd_s, r_rx[7:1]};

    // Reply byte for the current byte slot
    always_comb begin
        w_reply = 8'hFF;
        case (r_byte_idx)
            3'd1:    w_reply = 8'h41;
            3'd2:    w_reply = 8'h5A;
            3'd3:    w_reply = r_btn_lat[7:0];
            3'd4:    w_reply = r_btn_lat[15:8];
            default: w_reply = 8'hFF;
        endcase
    end

    // State register and datapath flops
    always_ff @(posedge sample_clk) begin
        if (!rst_n) begin
            r_att_sync <= '1;
            r_clk_sync <= '1;
            r_cmd_sync <= '1;
            r_att_d    <= 1'b1;
            r_clk_d    <= 1'b1;
            r_state    <= IDLE;
            r_ack      <= ACK_NONE;
            r_ack_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_rx       <= '0;
            r_btn_lat  <= '1;
            r_data     <= 1'b1;
            r_data_oe  <= 1'b0;
            r_ack_oe   <= 1'b0;
`ifdef PSX_POLL_SYNC_EN
            r_poll_req <= 1'b0;
`endif
        end else begin
            r_att_sync <= {r_att_sync[SYNC_STAGES-2:0], psx_att};
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], psx_clk};
            r_cmd_sync <= {r_cmd_sync[SYNC_STAGES-2:0], psx_cmd};
            r_att_d    <= w_att_s;
            r_clk_d    <= w_clk_s;
            r_state    <= w_state_nxt;
            r_ack      <= w_ack_nxt;
            r_ack_cnt  <= w_ack_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_rx       <= w_rx_nxt;
            r_btn_lat  <= w_btn_lat_nxt;
            r_data     <= w_data_nxt;
            r_data_oe  <= w_data_oe_nxt;
            r_ack_oe   <= w_ack_oe_nxt;
`ifdef PSX_POLL_SYNC_EN
            r_poll_req <= w_poll_nxt;
`endif
        end
    end

    // Next-state and output logic; ATT events outrank CLK edges
    always_comb begin
        w_state_nxt    = r_state;
        w_ack_nxt      = r_ack;
        w_ack_cnt_nxt  = r_ack_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_idx_nxt = r_byte_idx;
        w_rx_nxt       = r_rx;
        w_btn_lat_nxt  = r_btn_lat;
        w_data_nxt     = r_data;
        w_data_oe_nxt  = r_data_oe;
        w_ack_oe_nxt   = r_ack_oe;
        w_start_ack    = 1'b0;
`ifdef PSX_POLL_SYNC_EN
        w_poll_nxt     = 1'b0;
`endif
        if (w_att_rise || w_att_fall) begin
            w_state_nxt    = w_att_fall ? ADDR : IDLE;
            w_ack_nxt      = ACK_NONE;
            w_ack_cnt_nxt  = '0;
            w_bit_cnt_nxt  = '0;
            w_byte_idx_nxt = '0;
            w_rx_nxt       = '0;
            w_data_nxt     = 1'b1;
            w_data_oe_nxt  = 1'b0;
            w_ack_oe_nxt   = 1'b0;
`ifndef PSX_POLL_SYNC_EN
            if (w_att_fall) w_btn_lat_nxt = button_state;
`endif
        end else if (r_state != IDLE && r_state != IGNORE) begin
            // ACK sub-phase: delay countdown, then a fixed-width pulse
            case (r_ack)
                WAIT_ACK: begin
                    if (r_ack_cnt == '0) begin
                        w_ack_nxt     = ACKING;
                        w_ack_oe_nxt  = 1'b1;
                        w_ack_cnt_nxt = ACK_CW'(ACK_WIDTH - 1);
                    end else begin
                        w_ack_cnt_nxt = r_ack_cnt - ACK_CW'(1);
                    end
                end
                ACKING: begin
                    if (r_ack_cnt == '0) begin
                        w_ack_nxt    = ACK_NONE;
                        w_ack_oe_nxt = 1'b0;
                    end else begin
                        w_ack_cnt_nxt = r_ack_cnt - ACK_CW'(1);
                    end
                end
                default: ;
            endcase
            if (w_clk_fall) begin
                // next byte has started: drop any ACK still pending
                w_ack_nxt    = ACK_NONE;
                w_ack_oe_nxt = 1'b0;
                w_data_nxt   = r_data_oe ? w_reply[r_bit_cnt] : 1'b1;
            end else if (w_clk_rise) begin
                w_rx_nxt      = w_rx_byte;
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    w_byte_idx_nxt = r_byte_idx + 3'd1;
                    w_state_nxt    = IGNORE;
                    case (r_state)
                        ADDR: if (w_rx_byte == 8'h01) begin
                            w_state_nxt   = ID;
                            w_start_ack   = 1'b1;
                            w_data_oe_nxt = 1'b1;
`ifdef PSX_POLL_SYNC_EN
                            w_poll_nxt    = 1'b1;
`endif
                        end
                        ID: if (w_rx_byte == 8'h42) begin
                            w_state_nxt = HDR;
                            w_start_ack = 1'b1;
                        end
                        HDR: begin
                            w_state_nxt = BTN_LO;
                            w_start_ack = 1'b1;
`ifdef PSX_POLL_SYNC_EN
                            w_btn_lat_nxt = button_state;
`endif
                        end
                        BTN_LO: begin
                            w_state_nxt = BTN_HI;
                            w_start_ack = 1'b1;
                        end
                        default: ;
                    endcase
                    if (w_state_nxt == IGNORE) begin
                        w_data_nxt    = 1'b1;
                        w_data_oe_nxt = 1'b0;
                        w_ack_nxt     = ACK_NONE;
                        w_ack_oe_nxt  = 1'b0;
                    end
                end
            end
            if (w_start_ack) begin
                w_ack_nxt     = WAIT_ACK;
                w_ack_cnt_nxt = ACK_CW'(ACK_DELAY - 1);
            end
        end
    end

    assign psx_data    = r_data;
    assign psx_data_oe = r_data_oe;
    assign psx_ack_oe  = r_ack_oe;
`ifdef PSX_POLL_SYNC_EN
    assign poll_req    = r_poll_req;
`endif

endmodule

// File: tb/tb_psx_controller.sv
// tb_psx_controller: console-side stimulus for psx_controller. The driver pushes
// expected reply bytes and ACK widths into queues; independent monitors collect
// bytes on psx_clk rising edges and ACK pulses, and compare against the queues.
module tb_psx_controller;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned ACK_DELAY   = 40;
    localparam int unsigned ACK_WIDTH   = 80;
    localparam int unsigned HALF        = 16;

    typedef struct {
        logic [7:0] data;
        logic       oe;
    } exp_byte_t;

    logic        sample_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psx_att = 1'b1;
    logic        psx_clk = 1'b1;
    logic        psx_cmd = 1'b1;
    logic [15:0] button_state = 16'hFFFF;
    logic        psx_data, psx_data_oe, psx_ack_oe;
`ifdef PSX_POLL_SYNC_EN
    logic        poll_req;
`endif

    always #5 sample_clk = ~sample_clk;

    psx_controller #(
        .SYNC_STAGES(SYNC_STAGES),
        .ACK_DELAY  (ACK_DELAY),
        .ACK_WIDTH  (ACK_WIDTH)
    ) dut (
        .sample_clk  (sample_clk),
        .rst_n       (rst_n),
        .psx_att     (psx_att),
        .psx_clk     (psx_clk),
        .psx_cmd     (psx_cmd),
        .button_state(button_state),
        .psx_data    (psx_data),
        .psx_data_oe (psx_data_oe),
        .psx_ack_oe  (psx_ack_oe)
`ifdef PSX_POLL_SYNC_EN
        ,
        .poll_req    (poll_req)
`endif
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned cyc = 0;
    int unsigned byte_end_cyc = 0;
    int unsigned exp_polls = 0;
    int unsigned poll_hi = 0;
    bit          ack_ignore = 1'b0;
    exp_byte_t   exp_q[$];
    int unsigned ack_q[$];

    always @(posedge sample_clk) cyc <= cyc + 1;

`ifdef PSX_POLL_SYNC_EN
    always @(negedge sample_clk) if (poll_req === 1'b1) poll_hi = poll_hi + 1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic oe);
        exp_byte_t e;
        e.data = d;
        e.oe   = oe;
        exp_q.push_back(e);
    endtask

    // One console byte; optionally waits out a full ACK window afterwards
    task automatic send_byte(input logic [7:0] cmd, input logic [7:0] exp_d,
                             input logic exp_oe, input bit exp_ack, input bit do_wait);
        logic [7:0] c;
        c = cmd;
        push_exp(exp_d, exp_oe);
        if (exp_ack) ack_q.push_back(ACK_WIDTH);
        for (int i = 0; i < 8; i++) begin
            @(negedge sample_clk);
            psx_clk = 1'b0;
            psx_cmd = c[0];
            c = c >> 1;
            repeat (HALF) @(negedge sample_clk);
            psx_clk = 1'b1;
            if (i == 7) byte_end_cyc = cyc;
            repeat (HALF) @(negedge sample_clk);
        end
        psx_cmd = 1'b1;
        if (do_wait) repeat (ACK_DELAY + ACK_WIDTH + 20) @(negedge sample_clk);
    endtask

    task automatic att_low();
        @(negedge sample_clk);
        psx_att = 1'b0;
        repeat (10) @(negedge sample_clk);
    endtask

    task automatic att_high();
        @(negedge sample_clk);
        psx_att = 1'b1;
        repeat (20) @(negedge sample_clk);
    endtask

    task automatic full_poll(input logic [7:0] lo, input logic [7:0] hi);
        att_low();
        send_byte(8'h01, 8'hFF, 1'b0, 1'b1, 1'b1);
        exp_polls++;
        send_byte(8'h42, 8'h41, 1'b1, 1'b1, 1'b1);
        send_byte(8'h00, 8'h5A, 1'b1, 1'b1, 1'b1);
        send_byte(8'h00, lo,    1'b1, 1'b1, 1'b1);
        send_byte(8'h00, hi,    1'b1, 1'b0, 1'b1);
        att_high();
    endtask

    // Byte monitor: line value is 1 whenever the DUT releases DATA
    initial begin : data_mon
        logic [7:0] sh, oes;
        int         nb;
        exp_byte_t  e;
        nb = 0;
        sh = '0;
        oes = '0;
        forever begin
            @(posedge psx_clk or posedge psx_att);
            if (psx_att === 1'b1) begin
                if (nb != 0 && exp_q.size() != 0) e = exp_q.pop_front();
                nb = 0;
            end else begin
                sh  = {(psx_data_oe === 1'b1) ? psx_data : 1'b1, sh[7:1]};
                oes = {psx_data_oe, oes[7:1]};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_byte: got %02h, none expected", sh);
                    end else begin
                        e = exp_q.pop_front();
                        check("reply_byte", {24'd0, sh}, {24'd0, e.data});
                        check("reply_oe", {24'd0, oes}, {24'd0, {8{e.oe}}});
                    end
                end
            end
        end
    end

    // ACK monitor: width exact, start within synchronizer latency of ACK_DELAY
    initial begin : ack_mon
        int unsigned w, d, ew;
        forever begin
            @(negedge sample_clk);
            if (psx_ack_oe === 1'b1) begin
                d = cyc - byte_end_cyc;
                w = 0;
                while (psx_ack_oe === 1'b1 && w < 1000) begin
                    w++;
                    @(negedge sample_clk);
                end
                if (!ack_ignore) begin
                    if (ack_q.size() == 0) begin
                        check("unexpected_ack_width", w, 0);
                    end else begin
                        ew = ack_q.pop_front();
                        check("ack_width", w, ew);
                        n_checks++;
                        if (d >= ACK_DELAY && d <= ACK_DELAY + SYNC_STAGES + 2) n_pass++;
                        else $display("FAIL ack_delay: got %0d cycles, expected %0d..%0d",
                                      d, ACK_DELAY, ACK_DELAY + SYNC_STAGES + 2);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        int waited;
        // reset values
        rst_n = 1'b0;
        repeat (5) @(negedge sample_clk);
        check("rst_data", 32'(psx_data), 1);
        check("rst_data_oe", 32'(psx_data_oe), 0);
        check("rst_ack_oe", 32'(psx_ack_oe), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge sample_clk);

        // full poll, 4 ACKs, none after the last byte
        button_state = 16'hFFFE;
        full_poll(8'hFE, 8'hFF);

        // memory-card address: no ACK, data never driven
        att_low();
        send_byte(8'h81, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_byte(8'h42, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_byte(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        att_high();

        // bad command: ACK after byte 1 only, data released after byte 2
        att_low();
        send_byte(8'h01, 8'hFF, 1'b0, 1'b1, 1'b1);
        exp_polls++;
        send_byte(8'h43, 8'h41, 1'b1, 1'b0, 1'b1);
        send_byte(8'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
        att_high();

        // abort after 3 bits of BTN_LO
        button_state = 16'h1234;
        att_low();
        send_byte(8'h01, 8'hFF, 1'b0, 1'b1, 1'b1);
        exp_polls++;
        send_byte(8'h42, 8'h41, 1'b1, 1'b1, 1'b1);
        send_byte(8'h00, 8'h5A, 1'b1, 1'b1, 1'b1);
        push_exp(8'h34, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge sample_clk);
            psx_clk = 1'b0;
            psx_cmd = 1'b0;
            repeat (HALF) @(negedge sample_clk);
            psx_clk = 1'b1;
            repeat (HALF) @(negedge sample_clk);
        end
        check("abort_oe_before", 32'(psx_data_oe), 1);
        psx_att = 1'b1;
        repeat (SYNC_STAGES + 1) @(negedge sample_clk);
        check("abort_data_oe", 32'(psx_data_oe), 0);
        check("abort_data", 32'(psx_data), 1);
        check("abort_ack_oe", 32'(psx_ack_oe), 0);
        repeat (20) @(negedge sample_clk);
        button_state = 16'h0F0F;
        full_poll(8'h0F, 8'h0F);

        // reset while ACK is asserted
        ack_ignore = 1'b1;
        att_low();
        send_byte(8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
        exp_polls++;
        waited = 0;
        while (psx_ack_oe !== 1'b1 && waited < 300) begin
            @(negedge sample_clk);
            waited++;
        end
        check("ack_seen_before_reset", 32'(psx_ack_oe), 1);
        rst_n = 1'b0;
        @(negedge sample_clk);
        check("rst_mid_ack_oe", 32'(psx_ack_oe), 0);
        check("rst_mid_data_oe", 32'(psx_data_oe), 0);
        check("rst_mid_data", 32'(psx_data), 1);
        psx_att = 1'b1;
        repeat (5) @(negedge sample_clk);
        rst_n = 1'b1;
        repeat (30) @(negedge sample_clk);
        ack_ignore = 1'b0;
        check("post_rst_ack_oe", 32'(psx_ack_oe), 0);
        check("post_rst_data_oe", 32'(psx_data_oe), 0);

        // button_state changes between ADDR and ID byte
        button_state = 16'hFFFF;
        att_low();
        send_byte(8'h01, 8'hFF, 1'b0, 1'b1, 1'b1);
        exp_polls++;
        button_state = 16'hAAAA;
        send_byte(8'h42, 8'h41, 1'b1, 1'b1, 1'b1);
        send_byte(8'h00, 8'h5A, 1'b1, 1'b1, 1'b1);
`ifdef PSX_POLL_SYNC_EN
        send_byte(8'h00, 8'hAA, 1'b1, 1'b1, 1'b1);
        send_byte(8'h00, 8'hAA, 1'b1, 1'b0, 1'b1);
`else
        send_byte(8'h00, 8'hFF, 1'b1, 1'b1, 1'b1);
        send_byte(8'h00, 8'hFF, 1'b1, 1'b0, 1'b1);
`endif
        att_high();

        repeat (50) @(negedge sample_clk);
        check("pending_bytes", exp_q.size(), 0);
        check("pending_acks", ack_q.size(), 0);
`ifdef PSX_POLL_SYNC_EN
        check("poll_req_cycles", poll_hi, exp_polls);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
